// File: rtl/on_off_credit_tracker_if.sv
// ---------------------------------------------------------------------------
// on_off_credit_tracker_if : flit/credit pulses in, on/off + free counts out
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface on_off_credit_tracker_if #(
  parameter int PORT_NUM    = 5,
  parameter int VC_NUM      = 2,
  parameter int BUFFER_SIZE = 8
);
  localparam int CNT_W = $clog2(BUFFER_SIZE + 1);

  logic [PORT_NUM-1:0][VC_NUM-1:0]            flit_sent_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0]            credit_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0]            on_off_o;
  logic [PORT_NUM-1:0][VC_NUM-1:0][CNT_W-1:0] free_slots_o;
  logic                                       error_o;

  modport master (
    output flit_sent_i,
    output credit_i,
    input  on_off_o,
    input  free_slots_o,
    input  error_o
  );

  modport slave (
    input  flit_sent_i,
    input  credit_i,
    output on_off_o,
    output free_slots_o,
    output error_o
  );
endinterface

`default_nettype wire

// File: rtl/on_off_credit_tracker.sv
// ---------------------------------------------------------------------------
// on_off_credit_tracker : per-(port,vc) free-slot counters with on/off hysteresis
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module on_off_credit_tracker #(
  parameter int PORT_NUM      = 5,
  parameter int VC_NUM        = 2,
  parameter int BUFFER_SIZE   = 8,
  parameter int OFF_THRESHOLD = 2,
  parameter int ON_THRESHOLD  = 4
) (
  input  wire                       clk,
  input  wire                       rst,
  on_off_credit_tracker_if.slave    bus
);

  localparam int CNT_W = $clog2(BUFFER_SIZE + 1);

  localparam logic [CNT_W-1:0] c_full = CNT_W'(BUFFER_SIZE);
  localparam logic [CNT_W-1:0] c_off  = CNT_W'(OFF_THRESHOLD);
  localparam logic [CNT_W-1:0] c_on   = CNT_W'(ON_THRESHOLD);
  localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

  logic [PORT_NUM-1:0][VC_NUM-1:0] lane_err;
  logic [PORT_NUM-1:0]             port_err;
  logic                            error_q;
  logic                            error_d;

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
    // Two flits leaving one physical output in the same cycle is impossible.
    assign port_err[p] = ($countones(bus.flit_sent_i[p]) > 1);

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
      logic             sent;
      logic             cred;
      logic [CNT_W-1:0] free_q;
      logic [CNT_W-1:0] free_d;
      logic             on_off_q;
      logic             on_off_d;

      assign sent = bus.flit_sent_i[p][v];
      assign cred = bus.credit_i[p][v];

      always_comb begin
        free_d = free_q;
        if (sent && !cred && (free_q != '0)) begin
          free_d = free_q - c_one;
        end else if (cred && !sent && (free_q != c_full)) begin
          free_d = free_q + c_one;
        end
      end

      // Hysteresis is judged on the post-update count so on/off tracks it with no lag.
      always_comb begin
        on_off_d = on_off_q;
        if (free_d <= c_off) begin
          on_off_d = 1'b0;
        end else if (free_d >= c_on) begin
          on_off_d = 1'b1;
        end
      end

      assign lane_err[p][v] = (sent && !cred && (free_q == '0)) ||
                              (cred && !sent && (free_q == c_full));

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          free_q   <= c_full;
          on_off_q <= 1'b1;
        end else begin
          free_q   <= free_d;
          on_off_q <= on_off_d;
        end
      end

      assign bus.free_slots_o[p][v] = free_q;
      assign bus.on_off_o[p][v]     = on_off_q;
    end
  end

  always_comb begin
    error_d = error_q | (|lane_err) | (|port_err);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign bus.error_o = error_q;

endmodule

`default_nettype wire

// File: tb/tb_on_off_credit_tracker.sv
// ---------------------------------------------------------------------------
// tb_on_off_credit_tracker : scoreboard bench with a behavioural credit model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_on_off_credit_tracker;

  localparam int P    = 5;
  localparam int V    = 2;
  localparam int BUF  = 8;
  localparam int OFF  = 2;
  localparam int ON   = 4;
  localparam int CW   = $clog2(BUF + 1);

  typedef logic [P-1:0][V-1:0] vec_t;

  typedef struct {
    vec_t                       on;
    logic [P-1:0][V-1:0][CW-1:0] free;
    logic                       err;
    int                         step;
  } exp_t;

  logic clk;
  logic rst;

  on_off_credit_tracker_if #(.PORT_NUM(P), .VC_NUM(V), .BUFFER_SIZE(BUF)) bus_if ();

  on_off_credit_tracker #(
    .PORT_NUM(P), .VC_NUM(V), .BUFFER_SIZE(BUF),
    .OFF_THRESHOLD(OFF), .ON_THRESHOLD(ON)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  event chk_ev;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step     = 0;

  // Reference state: plain integers, one free count and one on flag per lane.
  int m_free [P][V];
  bit m_on   [P][V];
  bit m_err;

  task automatic model_reset();
    for (int p = 0; p < P; p++)
      for (int v = 0; v < V; v++) begin
        m_free[p][v] = BUF;
        m_on[p][v]   = 1'b1;
      end
    m_err = 1'b0;
  endtask

  task automatic model_step(input vec_t s, input vec_t c);
    for (int p = 0; p < P; p++) begin
      if ($countones(s[p]) > 1) m_err = 1'b1;
      for (int v = 0; v < V; v++) begin
        int delta;
        delta = int'(c[p][v]) - int'(s[p][v]);
        if (m_free[p][v] + delta < 0 || m_free[p][v] + delta > BUF) m_err = 1'b1;
        else m_free[p][v] = m_free[p][v] + delta;
        if (m_free[p][v] <= OFF)     m_on[p][v] = 1'b0;
        else if (m_free[p][v] >= ON) m_on[p][v] = 1'b1;
      end
    end
  endtask

  task automatic push_expected();
    exp_t e;
    for (int p = 0; p < P; p++)
      for (int v = 0; v < V; v++) begin
        e.on[p][v]   = m_on[p][v];
        e.free[p][v] = CW'(m_free[p][v]);
      end
    e.err  = m_err;
    e.step = step;
    exp_q.push_back(e);
    step++;
  endtask

  // One clock cycle of stimulus; the expected post-edge state is queued.
  task automatic drive(input vec_t s, input vec_t c, input logic r);
    @(negedge clk);
    rst                = r;
    bus_if.flit_sent_i = s;
    bus_if.credit_i    = c;
    if (!r) model_reset();
    else    model_step(s, c);
    push_expected();
  endtask

  // Reset asserted between edges; checked before the next rising edge arrives.
  task automatic async_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    push_expected();
    -> chk_ev;
    #2;
  endtask

  function automatic vec_t lane(input int p, input int v);
    vec_t m;
    m       = '0;
    m[p][v] = 1'b1;
    return m;
  endfunction

  function automatic vec_t rand_vec(input int pct);
    vec_t m;
    for (int p = 0; p < P; p++)
      for (int v = 0; v < V; v++)
        m[p][v] = ($urandom_range(0, 99) < pct);
    return m;
  endfunction

  function automatic vec_t rand_sent();
    vec_t m;
    m = '0;
    for (int p = 0; p < P; p++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 45)      m[p][$urandom_range(0, V - 1)] = 1'b1;
      else if (r < 47) m[p] = '1;
    end
    return m;
  endfunction

  // Monitor: outputs are valid every cycle, so any pending expectation is checked.
  initial begin
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_checks++;
        if (bus_if.free_slots_o !== e.free) begin
          n_fail++;
          $display("FAIL free_slots step=%0d actual=%h required=%h", e.step, bus_if.free_slots_o, e.free);
        end
        n_checks++;
        if (bus_if.on_off_o !== e.on) begin
          n_fail++;
          $display("FAIL on_off step=%0d actual=%b required=%b", e.step, bus_if.on_off_o, e.on);
        end
        n_checks++;
        if (bus_if.error_o !== e.err) begin
          n_fail++;
          $display("FAIL error step=%0d actual=%b required=%b", e.step, bus_if.error_o, e.err);
        end
      end
    end
  end

  initial begin
    vec_t z;
    z                  = '0;
    rst                = 1'b0;
    bus_if.flit_sent_i = '0;
    bus_if.credit_i    = '0;
    model_reset();

    // Pulses while held in reset are ignored.
    for (int i = 0; i < 4; i++) drive(rand_sent(), rand_vec(50), 1'b0);
    for (int i = 0; i < 3; i++) drive(z, z, 1'b1);

    // Drain lane [1][0] down to the OFF threshold, then walk the hysteresis band.
    for (int i = 0; i < 6; i++) drive(lane(1, 0), z, 1'b1);
    drive(z, lane(1, 0), 1'b1);
    drive(z, lane(1, 0), 1'b1);
    drive(lane(1, 0), z, 1'b1);
    drive(lane(1, 0), z, 1'b1);

    // Empty lane [3][1]; simultaneous send+credit at zero is legal, a lone send is not.
    for (int i = 0; i < 8; i++) drive(lane(3, 1), z, 1'b1);
    drive(lane(3, 1), lane(3, 1), 1'b1);
    drive(lane(3, 1), z, 1'b1);
    drive(z, z, 1'b1);
    drive(z, z, 1'b1);

    // Overflow at full.
    async_reset();
    drive(z, z, 1'b1);
    drive(z, lane(0, 0), 1'b1);
    drive(z, z, 1'b1);

    // Two VCs of one port sent in the same cycle.
    async_reset();
    drive(z, z, 1'b1);
    begin
      vec_t both;
      both    = '0;
      both[2] = '1;
      drive(both, z, 1'b1);
    end
    drive(z, z, 1'b1);

    // Asynchronous reset with lane [0][0] at 3 and still ON.
    async_reset();
    drive(z, z, 1'b1);
    for (int i = 0; i < 5; i++) drive(lane(0, 0), z, 1'b1);
    async_reset();
    drive(z, z, 1'b0);
    drive(z, z, 1'b1);

    // Randomized traffic with periodic resets to clear the sticky error.
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 249) begin
        async_reset();
        drive(z, z, 1'b1);
      end else if (i % 500 < 250) begin
        drive(rand_sent(), rand_vec(20), 1'b1);
      end else begin
        drive(rand_sent(), rand_vec(30), 1'b1);
      end
    end
    drive(z, z, 1'b1);

    begin
      int budget;
      budget = 20;
      while (exp_q.size() != 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      #2;
      if (exp_q.size() != 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/on_off_credit_tracker.md
Name: on_off_credit_tracker

Overview:
- Per output port and per downstream VC, tracks free buffer slots in the downstream router.
- Decrements on each flit forwarded through the crossbar and increments on each returned credit.
- Produces the registered on/off flow-control vector consumed by the switch allocators; a VC is only eligible for switch allocation while its bit is ON.
- Sits between the crossbar/output side and the allocator inputs, one instance per router.

Parameters:
PORT_NUM, 5, number of router output ports
VC_NUM, 2, virtual channels per port
BUFFER_SIZE, 8, downstream VC buffer depth in flits (>=2)
OFF_THRESHOLD, 2, on_off drops to OFF when free slots <= this value
ON_THRESHOLD, 4, on_off returns to ON when free slots >= this value; 0 <= OFF_THRESHOLD < ON_THRESHOLD <= BUFFER_SIZE
CNT_W, $clog2(BUFFER_SIZE+1), counter width (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
flit_sent_i  input  [PORT_NUM-1:0][VC_NUM-1:0]  1-cycle pulse: a flit left output port p toward downstream VC v; at most one bit per port per cycle
credit_i  input  [PORT_NUM-1:0][VC_NUM-1:0]  1-cycle pulse: downstream freed one slot of VC v on port p
on_off_o  output  [PORT_NUM-1:0][VC_NUM-1:0]  1 = downstream VC may accept flits
free_slots_o  output  [CNT_W-1:0] [PORT_NUM-1:0][VC_NUM-1:0]  current free-slot count per (port,vc)
error_o  output  1  sticky protocol-violation flag

Behaviour:
- Reset (rst low, asynchronous, any time including mid-traffic): every free_slots = BUFFER_SIZE, every on_off_o = 1, error_o = 0; pulses during reset are ignored. First update happens on the first rising edge after rst deasserts.
- Counter update per (p,v) each edge:
  - sent & !credit: free-1
  - credit & !sent: free+1
  - both asserted: unchanged (net zero, no error even at 0 or BUFFER_SIZE)
  - neither asserted: unchanged
- Underflow: sent & !credit while free==0: counter holds 0, error_o set.
- Overflow: credit & !sent while free==BUFFER_SIZE: counter holds BUFFER_SIZE, error_o set.
- Port violation: more than one flit_sent_i bit set within one port in a cycle sets error_o. Counters still update per bit.
- on_off next state is computed from free_next (the post-update value), so on_off_o and free_slots_o change on the same edge (0-cycle lag relative to counter):
  - free_next <= OFF_THRESHOLD: 0
  - else free_next >= ON_THRESHOLD: 1
  - else: hold previous value (hysteresis band)
- error_o is sticky until reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Each (p,v) is fully independent; no cross-VC or cross-port interaction except error_o OR-reduction.

Test Plan:
- Reset: hold rst=0, pulse inputs -> all free_slots_o=8, on_off_o all 1, error_o=0; release -> values unchanged until first pulse.
- Drain: with defaults, 6 consecutive flit_sent_i[1][0] pulses -> free_slots_o[1][0] goes 7,6,5,4,3,2; on_off_o[1][0] falls to 0 on the 6th edge (free=2); all other (p,v) unchanged.
- Hysteresis: from free=2/OFF, 1 credit -> free=3, on_off stays 0; 2nd credit -> free=4, on_off=1; 2 sends -> free=2, on_off=0 only then (stays 1 at free=3).
- Simultaneous: free=0, flit_sent_i and credit_i both on [3][1] -> free stays 0, error_o stays 0; then sent alone -> free stays 0, error_o=1 and remains 1.
- Overflow / port violation: credit at free=8 -> free stays 8, error_o=1; after reset, flit_sent_i[2]=2'b11 -> error_o=1, both counters of port 2 decrement to 7.
- Async reset mid-op: with free_slots_o[0][0]=3, on_off=1 hysteresis state, assert rst between edges -> outputs return to 8 / 1 / 0 immediately without waiting for a clock edge.
